// File: rtl/quadencoder_pkg.sv
// Shared mode constants and quadrature step classification for the encoder decoder.
package quadencoder_pkg;

    localparam int unsigned QUAD_X4 = 0;
    localparam int unsigned QUAD_X2 = 1;
    localparam int unsigned QUAD_X1 = 2;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_UP      = 2'd1,
        STEP_DOWN    = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_e;

    // ab_* are packed {A, B}; direction is up when prevA ^ nowB is set
    function automatic step_e decode_step(input logic [1:0] ab_prev, input logic [1:0] ab_now);
        logic da;
        logic db;
        step_e st;
        da = ab_prev[1] ^ ab_now[1];
        db = ab_prev[0] ^ ab_now[0];
        st = STEP_NONE;
        if (da && db) begin
            st = STEP_ILLEGAL;
        end else if (da || db) begin
            st = (ab_prev[1] ^ ab_now[0]) ? STEP_UP : STEP_DOWN;
        end
        return st;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser followed by a stable-count glitch filter for one encoder pin.
module quad_input_filter #(
    parameter int unsigned FILTER = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam int unsigned CW = (FILTER < 1) ? 1 : $clog2(FILTER + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] scnt_q;
    logic [CW-1:0] scnt_d;

    // Synchroniser carries no reset; it only ever holds pin samples
    always_ff @(posedge clk) begin
        sync1_q <= in;
        sync2_q <= sync1_q;
    end

    always_comb begin
        filt_d = filt_q;
        scnt_d = scnt_q;
        if (sync2_q == filt_q) begin
            scnt_d = '0;
        end else if (scnt_q == CW'(FILTER)) begin
            filt_d = sync2_q;
            scnt_d = '0;
        end else begin
            scnt_d = scnt_q + CW'(1);
        end
    end

    // Tracking the pin during reset avoids a phantom edge at release
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= sync2_q;
            scnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            scnt_q <= scnt_d;
        end
    end

    assign out = filt_q;

endmodule

// File: rtl/quadencoder_index.sv
// Quadrature x4 decoder with scaled position, armed index capture and sticky illegal-transition flag.
module quadencoder_index
    import quadencoder_pkg::*;
#(
    parameter int unsigned BITS        = 32,
    parameter int unsigned QUAD_TYPE   = QUAD_X4,
    parameter int unsigned FILTER      = 3,
    parameter int unsigned INDEX_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a,
    input  logic                   b,
    input  logic                   z,
    input  logic                   index_enable,
    input  logic                   err_clear,
    output logic signed [BITS-1:0] position,
    output logic signed [BITS-1:0] index_position,
    output logic                   index_ack,
    output logic                   error
);

    localparam logic ZERO_ON_INDEX = (INDEX_RESET != 0);

    logic fa;
    logic fb;
    logic fz;

    quad_input_filter #(.FILTER(FILTER)) u_filt_a (.clk(clk), .rst(rst), .in(a), .out(fa));
    quad_input_filter #(.FILTER(FILTER)) u_filt_b (.clk(clk), .rst(rst), .in(b), .out(fb));
    quad_input_filter #(.FILTER(FILTER)) u_filt_z (.clk(clk), .rst(rst), .in(z), .out(fz));

    logic [2:0]             prev_q;
    logic                   en_prev_q;
    logic                   armed_q;
    logic                   armed_d;
    logic signed [BITS-1:0] count_q;
    logic signed [BITS-1:0] count_d;
    logic signed [BITS-1:0] idx_q;
    logic signed [BITS-1:0] idx_d;
    logic                   ack_q;
    logic                   err_q;
    logic                   err_d;
    logic signed [BITS-1:0] pos_now;
    logic                   capture;
    step_e                  step;

    assign pos_now = count_q >>> QUAD_TYPE;

    always_comb begin
        step    = decode_step(prev_q[2:1], {fa, fb});
        capture = armed_q && !prev_q[0] && fz;
        count_d = count_q;
        err_d   = err_q;
        armed_d = armed_q;
        idx_d   = idx_q;

        case (step)
            STEP_UP:   count_d = count_q + BITS'(1);
            STEP_DOWN: count_d = count_q - BITS'(1);
            default:   count_d = count_q;
        endcase
        // Zero-on-index overrides any step decoded in the same cycle
        if (capture && ZERO_ON_INDEX) begin
            count_d = '0;
        end

        if (err_clear) begin
            err_d = 1'b0;
        end
        if (step == STEP_ILLEGAL) begin
            err_d = 1'b1;
        end

        if (index_enable && !en_prev_q) begin
            armed_d = 1'b1;
        end
        if (capture) begin
            armed_d = 1'b0;
            idx_d   = pos_now;
        end
    end

    // en_prev follows the level in reset so a held-high enable does not arm
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= {fa, fb, fz};
            en_prev_q <= index_enable;
            armed_q   <= 1'b0;
            count_q   <= '0;
            idx_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            prev_q    <= {fa, fb, fz};
            en_prev_q <= index_enable;
            armed_q   <= armed_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            ack_q     <= capture;
            err_q     <= err_d;
        end
    end

    assign position       = pos_now;
    assign index_position = idx_q;
    assign index_ack      = ack_q;
    assign error          = err_q;

endmodule
